// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS.cc BCD stopwatch on clk_50MHz ticked by clk_100Hz rising edges; in: reset, clk_100Hz, btn_start/lap/clear; out: six BCD digits, running, lap_active, overflow
module stopwatch_bcd #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       clk_100Hz,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;
  localparam logic [5:0][3:0] LIM = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  localparam logic [23:0] TOP = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 16'h5999};
  state_t state_q, state_d;
  logic [5:0][3:0] live_q, live_d, disp_q, disp_d;
  logic tick_prev_q, start_prev_q, lap_prev_q, clear_prev_q;
  logic running_q, running_d, lap_active_q, lap_active_d, overflow_q, overflow_d;
  logic tick, press_start, press_lap, press_clear, cnt_en, carry;
  always_comb begin
    tick = clk_100Hz & ~tick_prev_q;
    press_start = btn_start & ~start_prev_q;
    press_lap = btn_lap & ~lap_prev_q;
    press_clear = btn_clear & ~clear_prev_q;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = press_start ? RUN : IDLE;
      RUN: state_d = press_start ? PAUSE : press_lap ? LAP : RUN;
      LAP: state_d = press_start ? PAUSE : press_lap ? RUN : LAP;
      default: state_d = press_clear ? IDLE : press_start ? RUN : PAUSE;
    endcase
    cnt_en = tick && (state_q == RUN || state_q == LAP);
    carry = cnt_en;
    live_d = live_q;
    for (int i = 0; i < 6; i++) begin
      live_d[i] = carry ? (live_q[i] == LIM[i] ? 4'd0 : live_q[i] + 4'd1) : live_q[i];
      carry = carry && live_q[i] == LIM[i];
    end
    if (state_d == IDLE || (cnt_en && live_q == TOP)) live_d = '0;
    overflow_d = state_d != IDLE && (overflow_q || (cnt_en && live_q == TOP));
    disp_d = (state_q == LAP && state_d == LAP) ? disp_q : live_d;
    running_d = state_d == RUN || state_d == LAP;
    lap_active_d = state_d == LAP;
  end
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= IDLE;
      live_q <= '0;
      disp_q <= '0;
      running_q <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q <= 1'b0;
      tick_prev_q <= 1'b1;
      start_prev_q <= 1'b1;
      lap_prev_q <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      state_q <= state_d;
      live_q <= live_d;
      disp_q <= disp_d;
      running_q <= running_d;
      lap_active_q <= lap_active_d;
      overflow_q <= overflow_d;
      tick_prev_q <= clk_100Hz;
      start_prev_q <= btn_start;
      lap_prev_q <= btn_lap;
      clear_prev_q <= btn_clear;
    end
  end
  assign cs_ones = disp_q[0];
  assign cs_tens = disp_q[1];
  assign sec_ones = disp_q[2];
  assign sec_tens = disp_q[3];
  assign min_ones = disp_q[4];
  assign min_tens = disp_q[5];
  assign running = running_q;
  assign lap_active = lap_active_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed and random stimulus checked against a centisecond-integer reference model
module tb_stopwatch_bcd;
  localparam int MM = 2;
  localparam int TOTAL = (MM + 1) * 6000;
  logic clk = 1'b0, reset = 1'b1, c100 = 1'b0, bs = 1'b0, bl = 1'b0, bc = 1'b0;
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic running, lap_active, overflow;
  int tests = 0, failed = 0;
  int m_cnt = 0, m_disp = 0, m_st = 0;
  logic m_ovf = 1'b0, m_pc = 1'b1, m_ps = 1'b1, m_pl = 1'b1, m_pk = 1'b1;
  logic rs = 1'b0, rl = 1'b0, rk = 1'b0;

  stopwatch_bcd #(.MAX_MIN(MM)) dut (
    .clk_50MHz(clk), .reset(reset), .clk_100Hz(c100),
    .btn_start(bs), .btn_lap(bl), .btn_clear(bc),
    .cs_ones(cs_ones), .cs_tens(cs_tens), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  always #10 clk = ~clk;

  function automatic logic [23:0] bcd(input int d);
    int m, s, c;
    m = d / 6000;
    s = (d / 100) % 60;
    c = d % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic check(input string tag, input logic [23:0] exp_d, input logic exp_r, exp_l, exp_o);
    logic [23:0] obs;
    obs = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
    tests++;
    assert (obs === exp_d) else begin failed++; $error("FAIL %s digits got %h want %h", tag, obs, exp_d); end
    tests++;
    assert (running === exp_r) else begin failed++; $error("FAIL %s running got %b want %b", tag, running, exp_r); end
    tests++;
    assert (lap_active === exp_l) else begin failed++; $error("FAIL %s lap_active got %b want %b", tag, lap_active, exp_l); end
    tests++;
    assert (overflow === exp_o) else begin failed++; $error("FAIL %s overflow got %b want %b", tag, overflow, exp_o); end
  endtask

  task automatic cyc(input logic c, s, l, k, r);
    logic tk, ps, pl, pk;
    int nst;
    c100 = c; bs = s; bl = l; bc = k; reset = r;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_disp = 0; m_st = 0; m_ovf = 1'b0;
      m_pc = 1'b1; m_ps = 1'b1; m_pl = 1'b1; m_pk = 1'b1;
    end else begin
      tk = c & ~m_pc; ps = s & ~m_ps; pl = l & ~m_pl; pk = k & ~m_pk;
      nst = m_st;
      case (m_st)
        0: if (ps) nst = 1;
        1: if (ps) nst = 3; else if (pl) nst = 2;
        2: if (ps) nst = 3; else if (pl) nst = 1;
        default: if (pk) nst = 0; else if (ps) nst = 1;
      endcase
      if (tk && (m_st == 1 || m_st == 2)) begin
        m_cnt = (m_cnt + 1) % TOTAL;
        if (m_cnt == 0) m_ovf = 1'b1;
      end
      if (nst == 0) begin m_cnt = 0; m_ovf = 1'b0; end
      if (!(nst == 2 && m_st == 2)) m_disp = m_cnt;
      m_st = nst;
      m_pc = c; m_ps = s; m_pl = l; m_pk = k;
    end
    #1 check("model", bcd(m_disp), m_st == 1 || m_st == 2, m_st == 2, m_ovf);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("no_start_after_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (1000) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("held_start_one_press", 24'h000000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(100);
    check("one_second", 24'h000100, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tick_latency", 24'h000101, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(224);
    check("at_3_25", 24'h000325, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_snap", 24'h000325, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(50);
    check("lap_frozen", 24'h000325, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_release", 24'h000375, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(20);
    check("pause_frozen", 24'h000375, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("clear_wins", 24'h000000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(5999);
    check("at_59_99", 24'h005999, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check("minute_carry", 24'h010000, 1'b1, 1'b0, 1'b0);
    ticks(11999);
    check("before_wrap", 24'h025999, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check("wrap", 24'h000000, 1'b1, 1'b0, 1'b1);
    ticks(5);
    check("overflow_sticky", 24'h000005, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("start_lap_tick", 24'h000006, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_overflow", 24'h000000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(4217);
    check("at_42_17", 24'h004217, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_mid", 24'h000000, 1'b0, 1'b0, 1'b0);
    repeat (4000) begin
      if ($urandom_range(0, 15) == 0) rs = ~rs;
      if ($urandom_range(0, 15) == 0) rl = ~rl;
      if ($urandom_range(0, 63) == 0) rk = ~rk;
      cyc(1'($urandom_range(0, 1)), rs, rl, rk, $urandom_range(0, 799) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
